iir_scheduler: RTL and testbench

Round-robin scheduler that shares one first-order IIR datapath (codebase `adder`/`multiply` units, 16-bit float, sign in bit 15) among NCH sample channels. It holds per-channel filter state w1 and per-channel coefficient banks (shadow + active), arbitrates pending samples, and runs a 3-stage pipeline computing y = b0·w2 + b1·w1, where w2 = (x + OFFSET) + (−a1)·w1. It sits between the per-channel sample sources and the output sink, replacing one filter instance per channel.

---
 rtl/iir_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_iir_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_scheduler.sv
// Round-robin scheduler sharing one 3-stage first-order IIR datapath among NCH channels.
// Float format: sign[15], biased exp[14:10] (bias 15, exp 0 = zero), mantissa[9:0]; truncating, saturating.

module iir_ch_state (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        commit,
  input  logic        clr,
  input  logic        wb,
  input  logic [1:0]  sel,
  input  logic [15:0] data,
  input  logic [15:0] wb_data,
  output logic [15:0] a1,
  output logic [15:0] b0,
  output logic [15:0] b1,
  output logic [15:0] w1
);
  logic [2:0][15:0] shd_q, shd_d, act_q, act_d;
  logic [15:0]      w1_q, w1_d;

  // commit copies the pre-write shadow; clear overrides a same-edge writeback
  always_comb begin
    shd_d = shd_q;
    act_d = act_q;
    w1_d  = w1_q;
    if (commit) act_d = shd_q;
    if (we) begin
      case (sel)
        2'd0:    shd_d[0] = data;
        2'd1:    shd_d[1] = data;
        2'd2:    shd_d[2] = data;
        default: ;
      endcase
    end
    if (wb)  w1_d = wb_data;
    if (clr) w1_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd_q <= '0;
      act_q <= '0;
      w1_q  <= '0;
    end else begin
      shd_q <= shd_d;
      act_q <= act_d;
      w1_q  <= w1_d;
    end
  end

  assign a1 = act_q[0];
  assign b0 = act_q[1];
  assign b1 = act_q[2];
  assign w1 = w1_q;
endmodule

module iir_scheduler #(
  parameter int          NCH    = 4,
  parameter logic [15:0] OFFSET = 16'h8280,
  localparam int         CW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [16*NCH-1:0] req_x,
  output logic [NCH-1:0]    req_ready,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [15:0]       cfg_data,
  input  logic              cfg_commit,
  input  logic [NCH-1:0]    clr_ch,
  output logic              out_valid,
  output logic [CW-1:0]     out_ch,
  output logic [15:0]       out_y,
  output logic              busy
);
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [15:0]   x, a1, b0, b1, w1;
  } s1_t;
  typedef struct packed {
    logic [CW-1:0] ch;
    logic [15:0]   w2, w1, b0, b1;
  } s2_t;

  // operand as exact fixed point, LSB = 2^-24
  function automatic logic [42:0] fp_mag(input logic [15:0] f);
    if (f[14:10] == 5'd0) return '0;
    return 43'({1'b1, f[9:0]}) << (f[14:10] - 5'd1);
  endfunction

  function automatic logic [15:0] fp_pack(input logic sgn, input logic [42:0] mag);
    int p;
    p = -1;
    for (int i = 0; i < 43; i++) if (mag[i]) p = i;
    if (p < 10) return 16'h0000;
    if (p > 40) return {sgn, 15'h7fff};
    return {sgn, 5'(p - 9), 10'(mag >> (p - 10))};
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [42:0] ma, mb;
    ma = fp_mag(a);
    mb = fp_mag(b);
    if (a[15] == b[15]) return fp_pack(a[15], ma + mb);
    if (ma >= mb)       return fp_pack(a[15], ma - mb);
    return fp_pack(b[15], mb - ma);
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] pr;
    int          e;
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return 16'h0000;
    pr = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e  = int'(a[14:10]) + int'(b[14:10]) - 15 + (pr[21] ? 1 : 0);
    if (e < 1)  return 16'h0000;
    if (e > 31) return {a[15] ^ b[15], 15'h7fff};
    return {a[15] ^ b[15], 5'(e), pr[21] ? 10'(pr >> 11) : 10'(pr >> 10)};
  endfunction

  logic [NCH-1:0]       elig;
  logic                 gnt_vld;
  logic [CW-1:0]        gnt_ch, idx, ptr_q, ptr_d;
  logic [2:0]           vld_pipe_q, vld_pipe_d;
  s1_t                  s1_q, s1_d;
  s2_t                  s2_q, s2_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic [15:0]          out_y_q, out_y_d, w2, y;
  logic [NCH-1:0][15:0] ch_a1, ch_b0, ch_b1, ch_w1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    iir_ch_state u_st (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we && cfg_ch == CW'(i)),
      .commit  (cfg_commit && cfg_ch == CW'(i)),
      .clr     (clr_ch[i]),
      .wb      (vld_pipe_q[0] && s1_q.ch == CW'(i)),
      .sel     (cfg_sel),
      .data    (cfg_data),
      .wb_data (w2),
      .a1      (ch_a1[i]),
      .b0      (ch_b0[i]),
      .b1      (ch_b1[i]),
      .w1      (ch_w1[i])
    );
  end

  // scan downward so the last hit is the first eligible channel at/after the pointer
  always_comb begin
    elig      = req_valid & ~clr_ch;
    gnt_vld   = 1'b0;
    gnt_ch    = '0;
    idx       = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr_q + CW'(k);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_ch] = 1'b1;
    ptr_d = gnt_vld ? gnt_ch + 1'b1 : ptr_q;
  end

  assign w2 = fp_add(fp_add(s1_q.x, OFFSET), fp_mul({~s1_q.a1[15], s1_q.a1[14:0]}, s1_q.w1));
  assign y  = fp_add(fp_mul(s2_q.b0, s2_q.w2), fp_mul(s2_q.b1, s2_q.w1));

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1:0], gnt_vld};
    s1_d       = s1_q;
    s2_d       = s2_q;
    out_ch_d   = out_ch_q;
    out_y_d    = out_y_q;
    if (gnt_vld) begin
      s1_d.ch = gnt_ch;
      s1_d.x  = req_x[{gnt_ch, 4'd0} +: 16];
      s1_d.a1 = ch_a1[gnt_ch];
      s1_d.b0 = ch_b0[gnt_ch];
      s1_d.b1 = ch_b1[gnt_ch];
      // back-to-back on one channel: take w2 before it lands in the state array
      s1_d.w1 = (vld_pipe_q[0] && s1_q.ch == gnt_ch) ? w2 : ch_w1[gnt_ch];
    end
    if (vld_pipe_q[0]) begin
      s2_d.ch = s1_q.ch;
      s2_d.w2 = w2;
      s2_d.w1 = s1_q.w1;
      s2_d.b0 = s1_q.b0;
      s2_d.b1 = s1_q.b1;
    end
    if (vld_pipe_q[1]) begin
      out_ch_d = s2_q.ch;
      out_y_d  = y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_ch_q   <= '0;
      out_y_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      out_ch_q   <= out_ch_d;
      out_y_q    <= out_y_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign out_ch    = out_ch_q;
  assign out_y     = out_y_q;
  assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_iir_scheduler.sv
// Scoreboard bench for iir_scheduler: real-valued float model, grant-order IIR model, decoupled monitor.
module tb_iir_scheduler;
  localparam int          NCH = 4;
  localparam logic [15:0] OFF = 16'h8280;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_valid, req_ready, clr_ch;
  logic [16*NCH-1:0] req_x;
  logic              cfg_we, cfg_commit, out_valid, busy;
  logic [1:0]        cfg_ch, cfg_sel, out_ch;
  logic [15:0]       cfg_data, out_y;

  always #5 clk = ~clk;

  iir_scheduler #(.NCH(NCH), .OFFSET(OFF)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .clr_ch(clr_ch), .out_valid(out_valid), .out_ch(out_ch),
    .out_y(out_y), .busy(busy)
  );

  typedef struct { int due; logic [1:0] ch; logic [15:0] y; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // float semantics expressed through real arithmetic (all ops exact in double, then truncated)
  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] f);
    if (f[14:10] == 5'd0) return 0.0;
    return (f[15] ? -1.0 : 1.0) * (1.0 + real'(f[9:0]) / 1024.0) * p2(int'(f[14:10]) - 15);
  endfunction

  function automatic logic [15:0] r2f(input real v);
    real a; int e; logic s;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a < p2(-14)) return 16'h0000;
    if (a >= p2(17)) return {s, 15'h7fff};
    e = -14;
    for (int k = -14; k <= 16; k++) if (a >= p2(k)) e = k;
    return {s, 5'(e + 15), 10'($rtoi(a / p2(e) * 1024.0) - 1024)};
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  // reference state
  logic [15:0]    mw1[NCH];
  logic [15:0]    msh[NCH][3];
  logic [15:0]    mac[NCH][3];
  int             mptr;
  logic [NCH-1:0] pend;
  logic [15:0]    px[NCH];
  logic           c_we, c_cm;
  int             c_ch, c_sel;
  logic [15:0]    c_data;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mw1[i] = '0;
      for (int j = 0; j < 3; j++) begin msh[i][j] = '0; mac[i][j] = '0; end
    end
    mptr = 0; pend = '0; c_we = 0; c_cm = 0; c_ch = 0; c_sel = 0; c_data = '0;
    sbq.delete();
  endtask

  function automatic logic [15:0] rcoef();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(12, 15)), 10'($urandom)};
  endfunction

  task automatic step(input logic [NCH-1:0] nreq, input logic [NCH-1:0] clr);
    logic [NCH-1:0] elig, expr;
    logic [15:0] t, m, w2, y, w1;
    int g;
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      if (nreq[i] && !pend[i]) begin pend[i] = 1'b1; px[i] = 16'($urandom); end
    req_valid = pend;
    for (int i = 0; i < NCH; i++) req_x[16*i +: 16] = px[i];
    clr_ch = clr; cfg_we = c_we; cfg_commit = c_cm;
    cfg_ch = 2'(c_ch); cfg_sel = 2'(c_sel); cfg_data = c_data;
    #1;
    elig = pend & ~clr;
    g = -1;
    for (int k = 0; k < NCH; k++) if (g < 0 && elig[(mptr + k) % NCH]) g = (mptr + k) % NCH;
    expr = '0;
    if (g >= 0) expr[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(expr));
    if (g >= 0) begin
      w1 = mw1[g];
      t  = fadd(px[g], OFF);
      m  = r2f(-f2r(mac[g][0]) * f2r(w1));
      w2 = fadd(t, m);
      y  = fadd(fmul(mac[g][1], w2), fmul(mac[g][2], w1));
      sbq.push_back('{cyc + 3, 2'(g), y});
      mw1[g] = w2;
      mptr = (g + 1) % NCH;
      pend[g] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) if (clr[i]) mw1[i] = '0;
    if (c_cm) for (int j = 0; j < 3; j++) mac[c_ch][j] = msh[c_ch][j];
    if (c_we && c_sel < 3) msh[c_ch][c_sel] = c_data;
    c_we = 0; c_cm = 0;
  endtask

  task automatic wr(input int ch, input int sel, input logic [15:0] d, input logic cm);
    c_we = 1; c_ch = ch; c_sel = sel; c_data = d; c_cm = cm;
    step('0, '0);
  endtask

  task automatic commit(input int ch);
    c_cm = 1; c_ch = ch;
    step('0, '0);
  endtask

  task automatic load_all();
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < 3; s++) wr(c, s, rcoef(), 1'b0);
      commit(c);
    end
  endtask

  task automatic check_rst_outputs();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; clr_ch = '0; cfg_we = 0; cfg_commit = 0;
    model_reset();
    #1 check_rst_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an output
  initial forever begin
    exp_t e;
    logic bexp;
    @(posedge clk); #2;
    if (rst) begin
      bexp = 1'b0;
      foreach (sbq[j]) if (sbq[j].due - cyc >= 0 && sbq[j].due - cyc <= 2) bexp = 1'b1;
      chk("busy", 32'(busy), 32'(bexp));
      if (out_valid) begin
        if (sbq.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
        else begin
          e = sbq.pop_front();
          chk("out_cycle", cyc, e.due);
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_y", 32'(out_y), 32'(e.y));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_out_valid", 32'(out_valid), 1);
        void'(sbq.pop_front());
      end
    end else chk("out_valid_in_reset", 32'(out_valid), 0);
  end

  initial begin
    logic [15:0] nb0;
    rst = 1'b1; req_valid = '0; req_x = '0; clr_ch = '0;
    cfg_we = 0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; cfg_commit = 0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_rst_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // idle: zero coefficients, busy drains after last grant
    step(4'b0001, '0); step(4'b1000, '0); step(4'b0100, '0);
    repeat (5) step('0, '0);

    load_all();
    // round-robin with all channels requesting, then wrap from pointer 3 to ch2
    repeat (8) step(4'b1111, '0);
    step('0, '0); step(4'b0100, '0); step('0, '0); step(4'b0100, '0);
    repeat (4) step('0, '0);

    // same-channel burst exercises forwarding
    repeat (5) step(4'b0010, '0);
    repeat (4) step('0, '0);

    // coefficient timing
    nb0 = rcoef();
    wr(0, 1, nb0, 1'b0);
    step(4'b0001, '0);
    commit(0);
    step(4'b0001, '0);
    wr(0, 1, rcoef(), 1'b1);
    step(4'b0001, '0);
    commit(0);
    step(4'b0001, '0);
    repeat (4) step('0, '0);

    // clear collision and clear-blocked request
    step(4'b0001, '0);
    step('0, 4'b0001);
    step('0, '0);
    step(4'b0001, '0);
    step(4'b0001, 4'b0001);
    step(4'b0001, '0);
    step(4'b0011, 4'b0010);
    repeat (4) step('0, '0);

    // reset with three samples in flight
    repeat (3) step(4'b1111, '0);
    do_reset();
    repeat (4) step('0, '0);
    load_all();
    repeat (4) step(4'b1111, '0);
    repeat (4) step('0, '0);

    // randomized traffic
    repeat (400) begin
      logic [NCH-1:0] clr;
      clr = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 7) == 0) begin
        c_we = 1; c_ch = $urandom_range(0, NCH - 1); c_sel = $urandom_range(0, 3); c_data = rcoef();
      end
      if ($urandom_range(0, 9) == 0) begin
        c_cm = 1;
        if (!c_we) c_ch = $urandom_range(0, NCH - 1);
      end
      step(4'($urandom), clr);
    end
    repeat (6) step('0, '0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
